// File: rtl/serial_multiply.sv
// serial_multiply: iterative shift-add multiplier, one multiplier bit per
// enabled clock, with valid/ready handshakes and a pass-through tag.
module serial_multiply #(
   parameter int WIDTHA = 32,
   parameter int WIDTHB = 32,
   parameter int WIDTHP = 64,
   parameter int SIGNED = 0,
   parameter int TAGW   = 8
) (
   input  logic              clock,
   input  logic              aclr_n,
   input  logic              clken,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic [WIDTHA-1:0] dataa,
   input  logic [WIDTHB-1:0] datab,
   input  logic [TAGW-1:0]   tag_in,
   output logic              valid_out,
   input  logic              ready_out,
   output logic [WIDTHP-1:0] product,
   output logic [TAGW-1:0]   tag_out
);

   localparam int AW = WIDTHA + WIDTHB;
   localparam int PW = (WIDTHP > AW) ? WIDTHP : AW;
   localparam int CW = (WIDTHB > 1) ? $clog2(WIDTHB) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [AW-1:0]     mcand_q, mcand_d;
   logic [WIDTHB-1:0] mplier_q, mplier_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic [WIDTHP-1:0] prod_q, prod_d;

   logic              a_neg, b_neg, accept;
   logic [WIDTHA-1:0] a_mag;
   logic [WIDTHB-1:0] b_mag;
   logic [AW-1:0]     acc_nx;
   logic [PW-1:0]     ext, res;

   assign ready_in  = clken & ((state_q == S_IDLE) |
                               ((state_q == S_DONE) & ready_out));
   assign accept    = valid_in & ready_in;
   assign valid_out = (state_q == S_DONE);
   assign product   = prod_q;
   assign tag_out   = tag_q;

   always_comb begin
      a_neg  = (SIGNED != 0) && dataa[WIDTHA-1];
      b_neg  = (SIGNED != 0) && datab[WIDTHB-1];
      // -2^(W-1) negates to itself, which reads correctly as unsigned
      a_mag  = a_neg ? -dataa : dataa;
      b_mag  = b_neg ? -datab : datab;
      acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
      ext    = PW'(acc_nx);
      res    = neg_q ? -ext : ext;

      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      tag_d    = tag_q;
      prod_d   = prod_q;

      if (accept) begin
         state_d  = S_BUSY;
         mcand_d  = AW'(a_mag);
         mplier_d = b_mag;
         acc_d    = '0;
         cnt_d    = CW'(WIDTHB - 1);
         neg_d    = a_neg ^ b_neg;
         tag_d    = tag_in;
      end else if (clken) begin
         unique case (state_q)
            S_BUSY: begin
               acc_d    = acc_nx;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               if (cnt_q == '0) begin
                  state_d = S_DONE;
                  prod_d  = res[WIDTHP-1:0];
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_DONE: begin
               if (ready_out) state_d = S_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         tag_q    <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         tag_q    <= tag_d;
         prod_q   <= prod_d;
      end
   end

endmodule

// File: tb/tb_serial_multiply.sv
// tb_serial_multiply: unsigned, signed and signed-32-bit-product instances
// driven in parallel and compared against arithmetic reference products.
module tb_serial_multiply;

   logic        clock = 1'b0;
   logic        aclr_n, clken, valid_in, ready_out;
   logic [31:0] dataa, datab;
   logic [7:0]  tag_in;

   logic        rdy_u, rdy_s, rdy_t;
   logic        vo_u, vo_s, vo_t;
   logic [63:0] prod_u, prod_s;
   logic [31:0] prod_t;
   logic [7:0]  tag_u, tag_s, tag_t;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_u, exp_s, exp_t;
   logic [7:0]  exp_tag;

   always #5 clock = ~clock;

   serial_multiply u_dut (
      .clock(clock), .aclr_n(aclr_n), .clken(clken),
      .valid_in(valid_in), .ready_in(rdy_u),
      .dataa(dataa), .datab(datab), .tag_in(tag_in),
      .valid_out(vo_u), .ready_out(ready_out),
      .product(prod_u), .tag_out(tag_u)
   );

   serial_multiply #(.SIGNED(1)) u_sgn (
      .clock(clock), .aclr_n(aclr_n), .clken(clken),
      .valid_in(valid_in), .ready_in(rdy_s),
      .dataa(dataa), .datab(datab), .tag_in(tag_in),
      .valid_out(vo_s), .ready_out(ready_out),
      .product(prod_s), .tag_out(tag_s)
   );

   serial_multiply #(.SIGNED(1), .WIDTHP(32)) u_s32 (
      .clock(clock), .aclr_n(aclr_n), .clken(clken),
      .valid_in(valid_in), .ready_in(rdy_t),
      .dataa(dataa), .datab(datab), .tag_in(tag_in),
      .valid_out(vo_t), .ready_out(ready_out),
      .product(prod_t), .tag_out(tag_t)
   );

   function automatic logic [63:0] mul_u(input logic [31:0] a, b);
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic logic [63:0] mul_s(input logic [31:0] a, b);
      logic signed [63:0] x, y;
      x = $signed(a);
      y = $signed(b);
      return x * y;
   endfunction

   task automatic chk(input string tg, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tg, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_exp(input logic [31:0] a, b, input logic [7:0] t);
      exp_u   = mul_u(a, b);
      exp_s   = mul_s(a, b);
      exp_t   = {32'b0, exp_s[31:0]};
      exp_tag = t;
   endtask

   task automatic issue(input logic [31:0] a, b, input logic [7:0] t);
      dataa    = a;
      datab    = b;
      tag_in   = t;
      valid_in = 1'b1;
      #1;
      chk("ready_in_idle", rdy_u, 1);
      step();
      valid_in = 1'b0;
      set_exp(a, b, t);
   endtask

   task automatic wait_done(input int n0, output int lat, output logic rbad);
      int n;
      n    = n0;
      rbad = 1'b0;
      while (!vo_u && n < 200) begin
         if (rdy_u !== 1'b0) rbad = 1'b1;
         step();
         n++;
      end
      lat = n;
   endtask

   task automatic check_res(input string tg, input int lat, input int elat,
                            input logic rbad);
      chk({tg, "_latency"}, lat, elat);
      chk({tg, "_rdy_busy"}, rbad, 0);
      chk({tg, "_vo_sgn"}, {vo_s, vo_t}, 2'b11);
      chk({tg, "_prod_u"}, prod_u, exp_u);
      chk({tg, "_prod_s"}, prod_s, exp_s);
      chk({tg, "_prod_s32"}, prod_t, exp_t);
      chk({tg, "_tag"}, tag_u, exp_tag);
      chk({tg, "_tag_sgn"}, {tag_s, tag_t}, {exp_tag, exp_tag});
   endtask

   task automatic finish_op(input int hold);
      logic bad;
      bad = 1'b0;
      if (hold > 0) begin
         ready_out = 1'b0;
         repeat (hold) begin
            step();
            if (vo_u !== 1'b1 || prod_u !== exp_u || prod_s !== exp_s ||
                prod_t !== exp_t[31:0] || tag_u !== exp_tag ||
                rdy_u !== 1'b0)
               bad = 1'b1;
         end
         chk("hold_stable", bad, 0);
      end
      ready_out = 1'b1;
      step();
      chk("valid_drop", vo_u, 0);
   endtask

   task automatic do_op(input string tg, input logic [31:0] a, b,
                        input logic [7:0] t, input int hold);
      int   lat;
      logic rbad;
      issue(a, b, t);
      wait_done(1, lat, rbad);
      check_res(tg, lat, 33, rbad);
      finish_op(hold);
   endtask

   initial begin
      int   lat;
      logic rbad, bad;
      logic [31:0] ra, rb;

      aclr_n    = 1'b0;
      clken     = 1'b1;
      valid_in  = 1'b0;
      ready_out = 1'b1;
      dataa     = '0;
      datab     = '0;
      tag_in    = '0;
      #7;
      chk("rst_valid", {vo_u, vo_s, vo_t}, 0);
      chk("rst_product", prod_u | prod_s | {32'b0, prod_t}, 0);
      chk("rst_tag", {tag_u, tag_s, tag_t}, 0);
      chk("rst_ready_in", rdy_u, 1);
      #2 aclr_n = 1'b1;
      step();

      do_op("basic", 32'd56, 32'd11, 8'h5A, 0);
      do_op("max_u", 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h01, 0);
      do_op("zero_a", 32'd0, 32'h12345678, 8'h02, 0);
      do_op("neg7x3", 32'hFFFFFFF9, 32'd3, 8'h03, 0);
      do_op("min_sq", 32'h80000000, 32'h80000000, 8'h04, 0);
      do_op("min_x1", 32'h80000000, 32'd1, 8'h05, 0);

      // result held under backpressure, then back-to-back handoff
      ready_out = 1'b0;
      issue(32'd100, 32'd7, 8'h11);
      wait_done(1, lat, rbad);
      check_res("bp", lat, 33, rbad);
      bad = 1'b0;
      repeat (5) begin
         step();
         if (vo_u !== 1'b1 || prod_u !== exp_u || tag_u !== exp_tag ||
             prod_s !== exp_s || rdy_u !== 1'b0)
            bad = 1'b1;
      end
      chk("bp_stable", bad, 0);
      dataa     = 32'd3;
      datab     = 32'd4;
      tag_in    = 8'h22;
      valid_in  = 1'b1;
      ready_out = 1'b1;
      #1;
      chk("b2b_ready_in", rdy_u, 1);
      chk("b2b_valid_out", vo_u, 1);
      step();
      valid_in = 1'b0;
      set_exp(32'd3, 32'd4, 8'h22);
      chk("b2b_busy", vo_u, 0);
      wait_done(1, lat, rbad);
      check_res("b2b", lat, 33, rbad);
      chk("b2b_prod12", prod_u, 64'd12);
      finish_op(0);

      // clock-enable stall mid-BUSY
      issue(32'd56, 32'd11, 8'h5A);
      repeat (10) step();
      clken = 1'b0;
      #1;
      bad = 1'b0;
      repeat (4) begin
         if (rdy_u !== 1'b0 || vo_u !== 1'b0) bad = 1'b1;
         step();
      end
      clken = 1'b1;
      chk("stall_frozen", bad, 0);
      wait_done(15, lat, rbad);
      check_res("stall", lat, 37, rbad);
      chk("stall_prod616", prod_u, 64'd616);
      finish_op(2);

      // asynchronous reset mid-BUSY
      issue(32'd9, 32'd9, 8'h33);
      repeat (10) step();
      #2 aclr_n = 1'b0;
      #1;
      chk("arst_valid", {vo_u, vo_s, vo_t}, 0);
      chk("arst_product", prod_u | prod_s | {32'b0, prod_t}, 0);
      chk("arst_tag", tag_u, 0);
      chk("arst_idle", rdy_u, 1);
      #3 aclr_n = 1'b1;
      step();
      do_op("post_rst", 32'd2, 32'd2, 8'h44, 0);
      chk("post_rst_prod4", prod_u, 64'd4);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         do_op("rand", ra, rb, 8'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
